// File: rtl/ex_branch_resolve.sv
// Conditional-branch stash between IF and EX: records predictions, trains the predictor on
// resolution and redirects fetch on a mispredict. Optional statistics: EX_BRANCH_STATS_EN.
module ex_branch_resolve #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_branch_valid,
  input  logic [31:0] if_branch_pc,
  input  logic        if_prediction_take,
  input  logic [31:0] if_pc_alt,
  input  logic        ex_branch_valid,
  input  logic        ex_branch_take,
  input  logic        pipe_flush,
  output logic        pc_jmp_feedback,
  output logic        pc_jmp_take,
  output logic [31:0] pc_stash_base,
  output logic        pc_redirect,
  output logic [31:0] pc_redirect_target,
  output logic        stash_full,
  output logic        stash_err,
  output logic [31:0] stat_resolved,
  output logic [31:0] stat_mispredict
);

  // Entry layout: {pc[64:33], prediction[32], alt[31:0]}
  logic [64:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_feedback;
  logic             r_take;
  logic [31:0]      r_base;
  logic             r_redirect;
  logic [31:0]      r_target;
  logic             r_err;

  logic [64:0] w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;
  logic        w_mis;
  logic        w_discard;
  logic        w_err;

  assign w_head    = r_mem[r_rd_ptr];
  assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = ex_branch_valid && !w_empty;
  // A pop frees the head slot in the same cycle, so a push is accepted even when full.
  assign w_push    = if_branch_valid && (!w_full || w_pop);
  assign w_mis     = w_pop && (ex_branch_take != w_head[32]);
  assign w_discard = w_mis || pipe_flush;
  assign w_err     = (if_branch_valid && w_full && !w_pop) || (ex_branch_valid && w_empty);

  always_ff @(posedge clk) begin
    if (w_push && !w_discard) begin
      r_mem[r_wr_ptr] <= {if_branch_pc, if_prediction_take, if_pc_alt};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_feedback <= 1'b0;
      r_take     <= 1'b0;
      r_base     <= 32'h0;
      r_redirect <= 1'b0;
      r_target   <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      if (w_discard) begin
        r_rd_ptr <= r_wr_ptr;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
      end
      r_feedback <= w_pop;
      r_redirect <= w_mis;
      if (w_pop) begin
        r_take <= ex_branch_take;
        r_base <= w_head[64:33];
      end
      if (w_mis) r_target <= w_head[31:0];
      if (w_err) r_err <= 1'b1;
    end
  end

  assign pc_jmp_feedback    = r_feedback;
  assign pc_jmp_take        = r_take;
  assign pc_stash_base      = r_base;
  assign pc_redirect        = r_redirect;
  assign pc_redirect_target = r_target;
  assign stash_full         = w_full;
  assign stash_err          = r_err;

`ifdef EX_BRANCH_STATS_EN
  logic [31:0] r_stat_resolved;
  logic [31:0] r_stat_mispredict;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_resolved   <= 32'h0;
      r_stat_mispredict <= 32'h0;
    end else begin
      if (w_pop) r_stat_resolved   <= r_stat_resolved + 32'd1;
      if (w_mis) r_stat_mispredict <= r_stat_mispredict + 32'd1;
    end
  end

  assign stat_resolved   = r_stat_resolved;
  assign stat_mispredict = r_stat_mispredict;
`else
  assign stat_resolved   = 32'h0;
  assign stat_mispredict = 32'h0;
`endif

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Bench for ex_branch_resolve: directed vector table, then randomized traffic checked
// against a queue-based model of the stash.
module tb_ex_branch_resolve;

  localparam int DEPTH = 4;
`ifdef EX_BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_branch_valid = 1'b0;
  logic [31:0] if_branch_pc = 32'h0;
  logic        if_prediction_take = 1'b0;
  logic [31:0] if_pc_alt = 32'h0;
  logic        ex_branch_valid = 1'b0;
  logic        ex_branch_take = 1'b0;
  logic        pipe_flush = 1'b0;
  logic        pc_jmp_feedback;
  logic        pc_jmp_take;
  logic [31:0] pc_stash_base;
  logic        pc_redirect;
  logic [31:0] pc_redirect_target;
  logic        stash_full;
  logic        stash_err;
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispredict;

  ex_branch_resolve #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .if_branch_valid(if_branch_valid), .if_branch_pc(if_branch_pc),
    .if_prediction_take(if_prediction_take), .if_pc_alt(if_pc_alt),
    .ex_branch_valid(ex_branch_valid), .ex_branch_take(ex_branch_take),
    .pipe_flush(pipe_flush),
    .pc_jmp_feedback(pc_jmp_feedback), .pc_jmp_take(pc_jmp_take),
    .pc_stash_base(pc_stash_base), .pc_redirect(pc_redirect),
    .pc_redirect_target(pc_redirect_target), .stash_full(stash_full),
    .stash_err(stash_err), .stat_resolved(stat_resolved),
    .stat_mispredict(stat_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic push; logic [31:0] pc; logic pred; logic [31:0] alt;
    logic pop; logic take; logic flush;
    logic fb; logic tk; logic [31:0] base; logic rd; logic [31:0] tgt;
    logic full; logic err; int res; int mis;
  } vec_t;

  typedef struct { logic [31:0] pc; logic pred; logic [31:0] alt; } entry_t;

  vec_t   vt[43];
  entry_t m_q[$];
  logic   m_fb, m_tk, m_rd, m_err;
  logic [31:0] m_base, m_tgt, m_res, m_mis;
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t row(logic rst, logic push, logic [31:0] pc, logic pred, logic [31:0] alt,
                               logic pop, logic take, logic flush, logic fb, logic tk,
                               logic [31:0] base, logic rd, logic [31:0] tgt, logic full,
                               logic err, int res, int mis);
    vec_t v;
    v.rst = rst; v.push = push; v.pc = pc; v.pred = pred; v.alt = alt;
    v.pop = pop; v.take = take; v.flush = flush; v.fb = fb; v.tk = tk;
    v.base = base; v.rd = rd; v.tgt = tgt; v.full = full; v.err = err;
    v.res = res; v.mis = mis;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Reference behaviour of one clock edge, straight from the stash rules.
  task automatic model_edge(input logic rst, input logic push, input logic [31:0] pc, input logic pred,
                            input logic [31:0] alt, input logic pop, input logic take, input logic flush);
    bit full_before, popped, mis;
    entry_t e, h;
    if (rst) begin
      m_q.delete();
      m_fb = 0; m_tk = 0; m_rd = 0; m_err = 0;
      m_base = 0; m_tgt = 0; m_res = 0; m_mis = 0;
      return;
    end
    full_before = (m_q.size() == DEPTH);
    popped = pop && (m_q.size() != 0);
    mis = 0;
    if (pop && m_q.size() == 0) m_err = 1;
    if (push && full_before && !popped) m_err = 1;
    m_fb = popped; m_rd = 0;
    if (popped) begin
      h = m_q.pop_front();
      m_tk = take; m_base = h.pc; m_res = m_res + 1;
      if (take != h.pred) begin
        mis = 1; m_rd = 1; m_tgt = h.alt; m_mis = m_mis + 1;
      end
    end
    if (mis || flush) m_q.delete();
    else if (push && (!full_before || popped)) begin
      e.pc = pc; e.pred = pred; e.alt = alt;
      m_q.push_back(e);
    end
  endtask

  task automatic step(input logic rst, input logic push, input logic [31:0] pc, input logic pred,
                      input logic [31:0] alt, input logic pop, input logic take, input logic flush);
    reset = rst; if_branch_valid = push; if_branch_pc = pc; if_prediction_take = pred;
    if_pc_alt = alt; ex_branch_valid = pop; ex_branch_take = take; pipe_flush = flush;
    @(posedge clk);
    #1;
    model_edge(rst, push, pc, pred, alt, pop, take, flush);
  endtask

  task automatic check_model(input int idx);
    chk("feedback", idx, 32'(pc_jmp_feedback), 32'(m_fb));
    chk("take", idx, 32'(pc_jmp_take), 32'(m_tk));
    chk("base", idx, pc_stash_base, m_base);
    chk("redirect", idx, 32'(pc_redirect), 32'(m_rd));
    chk("target", idx, pc_redirect_target, m_tgt);
    chk("full", idx, 32'(stash_full), 32'(m_q.size() == DEPTH));
    chk("err", idx, 32'(stash_err), 32'(m_err));
    chk("stat_res", idx, stat_resolved, STATS ? m_res : 32'h0);
    chk("stat_mis", idx, stat_mispredict, STATS ? m_mis : 32'h0);
  endtask

  initial begin
    //            rst push pc       pr alt      pop tk fl | fb tk base     rd tgt      fu er res mis
    vt[0]  = row(1, 0, 32'h0,   0, 32'h0,   0, 0, 0,  0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0);
    vt[1]  = row(0, 1, 32'h100, 1, 32'h104, 0, 0, 0,  0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0);
    vt[2]  = row(0, 0, 32'h0,   0, 32'h0,   1, 1, 0,  1, 1, 32'h100, 0, 32'h0,   0, 0, 1, 0);
    vt[3]  = row(0, 1, 32'h200, 1, 32'h204, 0, 0, 0,  0, 1, 32'h100, 0, 32'h0,   0, 0, 1, 0);
    vt[4]  = row(0, 1, 32'h300, 1, 32'h304, 0, 0, 0,  0, 1, 32'h100, 0, 32'h0,   0, 0, 1, 0);
    vt[5]  = row(0, 0, 32'h0,   0, 32'h0,   1, 0, 0,  1, 0, 32'h200, 1, 32'h204, 0, 0, 2, 1);
    vt[6]  = row(0, 0, 32'h0,   0, 32'h0,   1, 1, 0,  0, 0, 32'h200, 0, 32'h204, 0, 1, 2, 1);
    vt[7]  = row(1, 0, 32'h0,   0, 32'h0,   0, 0, 0,  0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0);
    vt[8]  = row(0, 1, 32'h10,  0, 32'h14,  0, 0, 0,  0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0);
    vt[9]  = row(0, 1, 32'h20,  0, 32'h24,  0, 0, 0,  0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0);
    vt[10] = row(0, 1, 32'h30,  0, 32'h34,  0, 0, 0,  0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0);
    vt[11] = row(0, 1, 32'h40,  0, 32'h44,  0, 0, 0,  0, 0, 32'h0,   0, 32'h0,   1, 0, 0, 0);
    vt[12] = row(0, 1, 32'h50,  0, 32'h54,  0, 0, 0,  0, 0, 32'h0,   0, 32'h0,   1, 1, 0, 0);
    vt[13] = row(0, 1, 32'h60,  0, 32'h64,  1, 0, 0,  1, 0, 32'h10,  0, 32'h0,   1, 1, 1, 0);
    vt[14] = row(0, 1, 32'h70,  0, 32'h74,  1, 0, 0,  1, 0, 32'h20,  0, 32'h0,   1, 1, 2, 0);
    vt[15] = row(0, 0, 32'h0,   0, 32'h0,   1, 0, 0,  1, 0, 32'h30,  0, 32'h0,   0, 1, 3, 0);
    vt[16] = row(0, 0, 32'h0,   0, 32'h0,   1, 0, 0,  1, 0, 32'h40,  0, 32'h0,   0, 1, 4, 0);
    vt[17] = row(0, 0, 32'h0,   0, 32'h0,   1, 0, 0,  1, 0, 32'h60,  0, 32'h0,   0, 1, 5, 0);
    vt[18] = row(0, 0, 32'h0,   0, 32'h0,   1, 0, 0,  1, 0, 32'h70,  0, 32'h0,   0, 1, 6, 0);
    vt[19] = row(0, 1, 32'hA0,  1, 32'hA4,  0, 0, 0,  0, 0, 32'h70,  0, 32'h0,   0, 1, 6, 0);
    vt[20] = row(0, 1, 32'hB0,  1, 32'hB4,  0, 0, 0,  0, 0, 32'h70,  0, 32'h0,   0, 1, 6, 0);
    vt[21] = row(0, 1, 32'hC0,  1, 32'hC4,  0, 0, 0,  0, 0, 32'h70,  0, 32'h0,   0, 1, 6, 0);
    vt[22] = row(0, 1, 32'hD0,  1, 32'hD4,  0, 0, 1,  0, 0, 32'h70,  0, 32'h0,   0, 1, 6, 0);
    vt[23] = row(0, 0, 32'h0,   0, 32'h0,   1, 1, 0,  0, 0, 32'h70,  0, 32'h0,   0, 1, 6, 0);
    vt[24] = row(1, 0, 32'h0,   0, 32'h0,   0, 0, 0,  0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0);
    vt[25] = row(0, 1, 32'hE0,  0, 32'hE4,  0, 0, 0,  0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0);
    vt[26] = row(0, 0, 32'h0,   0, 32'h0,   1, 1, 0,  1, 1, 32'hE0,  1, 32'hE4,  0, 0, 1, 1);
    vt[27] = row(1, 0, 32'h0,   0, 32'h0,   0, 0, 0,  0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0);
    vt[28] = row(0, 1, 32'hF0,  1, 32'hF4,  0, 0, 0,  0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0);
    vt[29] = row(1, 0, 32'h0,   0, 32'h0,   1, 1, 0,  0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0);
    vt[30] = row(0, 1, 32'h11,  1, 32'h15,  0, 0, 0,  0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0);
    vt[31] = row(0, 1, 32'h21,  0, 32'h25,  0, 0, 0,  0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0);
    vt[32] = row(0, 0, 32'h0,   0, 32'h0,   1, 1, 0,  1, 1, 32'h11,  0, 32'h0,   0, 0, 1, 0);
    vt[33] = row(0, 0, 32'h0,   0, 32'h0,   1, 0, 0,  1, 0, 32'h21,  0, 32'h0,   0, 0, 2, 0);
    vt[34] = row(0, 1, 32'h31,  0, 32'h35,  0, 0, 0,  0, 0, 32'h21,  0, 32'h0,   0, 0, 2, 0);
    vt[35] = row(0, 0, 32'h0,   0, 32'h0,   1, 1, 0,  1, 1, 32'h31,  1, 32'h35,  0, 0, 3, 1);
    vt[36] = row(0, 1, 32'h41,  1, 32'h45,  0, 0, 0,  0, 1, 32'h31,  0, 32'h35,  0, 0, 3, 1);
    vt[37] = row(0, 1, 32'h51,  1, 32'h55,  0, 0, 0,  0, 1, 32'h31,  0, 32'h35,  0, 0, 3, 1);
    vt[38] = row(0, 0, 32'h0,   0, 32'h0,   1, 1, 1,  1, 1, 32'h41,  0, 32'h35,  0, 0, 4, 1);
    vt[39] = row(0, 0, 32'h0,   0, 32'h0,   1, 1, 0,  0, 1, 32'h41,  0, 32'h35,  0, 1, 4, 1);
    vt[40] = row(0, 1, 32'h61,  0, 32'h65,  0, 0, 0,  0, 1, 32'h41,  0, 32'h35,  0, 1, 4, 1);
    vt[41] = row(0, 1, 32'h71,  0, 32'h75,  1, 1, 0,  1, 1, 32'h61,  1, 32'h65,  0, 1, 5, 2);
    vt[42] = row(0, 0, 32'h0,   0, 32'h0,   1, 1, 0,  0, 1, 32'h61,  0, 32'h65,  0, 1, 5, 2);

    for (int i = 0; i < 43; i++) begin
      step(vt[i].rst, vt[i].push, vt[i].pc, vt[i].pred, vt[i].alt,
           vt[i].pop, vt[i].take, vt[i].flush);
      chk("feedback", i, 32'(pc_jmp_feedback), 32'(vt[i].fb));
      chk("take", i, 32'(pc_jmp_take), 32'(vt[i].tk));
      chk("base", i, pc_stash_base, vt[i].base);
      chk("redirect", i, 32'(pc_redirect), 32'(vt[i].rd));
      chk("target", i, pc_redirect_target, vt[i].tgt);
      chk("full", i, 32'(stash_full), 32'(vt[i].full));
      chk("err", i, 32'(stash_err), 32'(vt[i].err));
      chk("stat_res", i, stat_resolved, STATS ? 32'(vt[i].res) : 32'h0);
      chk("stat_mis", i, stat_mispredict, STATS ? 32'(vt[i].mis) : 32'h0);
    end

    // Randomized traffic against the queue model, starting from a clean reset.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check_model(1000);
    for (int c = 0; c < 3000; c++) begin
      logic r_rst, r_push, r_pred, r_pop, r_take, r_flush;
      logic [31:0] r_pc, r_alt;
      r_rst   = ($urandom_range(0, 199) == 0);
      r_push  = ($urandom_range(0, 9) < 5);
      r_pop   = ($urandom_range(0, 9) < 4);
      r_flush = ($urandom_range(0, 39) == 0);
      r_pred  = 1'($urandom_range(0, 1));
      r_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      r_alt   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      // Mostly predict correctly so the stash actually fills up.
      if (m_q.size() != 0 && $urandom_range(0, 9) < 8) r_take = m_q[0].pred;
      else r_take = 1'($urandom_range(0, 1));
      step(r_rst, r_push, r_pc, r_pred, r_alt, r_pop, r_take, r_flush);
      check_model(1001 + c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_branch_resolve.md
EX_BRANCH_RESOLVE -- requirements
Module: ex_branch_resolve

Interface
REQ-001 Parameter DEPTH, default 4, in-flight conditional-branch stash entries; power of two, minimum 2.
REQ-002 Parameter PTR_W, default 2, pointer width; log2(DEPTH).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 if_branch_valid  in  1  IF issued a conditional branch this cycle (push).
REQ-006 if_branch_pc  in  32  PC of that branch, which is the predictor index base.
REQ-007 if_prediction_take  in  1  prediction the predictor gave for that branch.
REQ-008 if_pc_alt  in  32  not-followed path: fall-through if predicted taken, target if predicted not-taken.
REQ-009 ex_branch_valid  in  1  EX resolved the oldest in-flight conditional branch (pop).
REQ-010 ex_branch_take  in  1  actual outcome of that branch.
REQ-011 pipe_flush  in  1  external flush (jal, exception); discards all stash entries.
REQ-012 pc_jmp_feedback  out  1  one-cycle strobe to the predictor: train now.
REQ-013 pc_jmp_take  out  1  actual outcome accompanying pc_jmp_feedback.
REQ-014 pc_stash_base  out  32  stashed branch PC accompanying pc_jmp_feedback.
REQ-015 pc_redirect  out  1  one-cycle strobe: mispredict, refetch.
REQ-016 pc_redirect_target  out  32  refetch address (stashed if_pc_alt).
REQ-017 stash_full  out  1  count == DEPTH; IF shall not push.
REQ-018 stash_err  out  1  sticky: push while full, or pop while empty.
REQ-019 stat_resolved, stat_mispredict  out  32 each  statistics counters (see Configuration).

Function
REQ-020 Stash shall be a circular FIFO of DEPTH entries {pc, prediction, alt}; read and write pointers wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-021 Push when if_branch_valid=1 and not full; pop when ex_branch_valid=1 and not empty; simultaneous push and pop shall be legal at any count, including full, and shall leave count unchanged.
REQ-022 On pop, the next cycle shall present pc_jmp_feedback=1, pc_jmp_take=ex_branch_take, pc_stash_base=head pc (one-cycle latency, registered outputs).
REQ-023 Mispredict = pop with ex_branch_take != head prediction; the next cycle shall present pc_redirect=1 and pc_redirect_target=head alt, concurrent with the feedback strobe.
REQ-024 On mispredict, all entries, including any same-cycle push, shall be discarded: pointers equal, count=0.
REQ-025 pipe_flush=1 shall discard all entries, including any same-cycle push; a same-cycle pop shall still produce its feedback and redirect.
REQ-026 Push while full shall be dropped and shall set stash_err; pop while empty shall produce no strobe and shall set stash_err.
REQ-027 Strobe outputs shall be 0 in every cycle not following a valid pop; pc_stash_base and pc_redirect_target shall hold their last values.

Reset
REQ-028 While reset=1: pointers, count, stash_full, stash_err, pc_jmp_feedback, pc_jmp_take, pc_redirect shall be 0; pc_stash_base and pc_redirect_target shall be 32'h0; stat counters shall be 0.
REQ-029 Reset shall take priority over push, pop and pipe_flush in the same cycle; an in-flight strobe shall be cancelled.

Configuration
REQ-030 With macro EX_BRANCH_STATS_EN defined: stat_resolved shall increment on each valid pop and stat_mispredict on each mispredict, both wrapping at 2^32.
REQ-031 Without EX_BRANCH_STATS_EN: stat_resolved and stat_mispredict shall be constant 0, and no counter flops shall be synthesized.

Verification
REQ-032 Push pc=0x100 pred=1 alt=0x104; pop take=1 -> next cycle feedback=1, take=1, base=0x100, redirect=0.
REQ-033 Push pc=0x200 pred=1 alt=0x204, then push 0x300; pop take=0 -> next cycle redirect=1, target=0x204, feedback base=0x200; count=0 after.
REQ-034 Push 4 entries -> stash_full=1; 5th push dropped, stash_err=1; push and pop in the same cycle while full -> count stays 4, FIFO order preserved across pointer wrap.
REQ-035 Pop on empty -> no strobe, stash_err=1; pipe_flush with 3 entries and a same-cycle push -> count=0.
REQ-036 Reset asserted in the cycle after a pop -> strobes 0 that cycle, all outputs at their reset values; with EX_BRANCH_STATS_EN, 3 pops including 1 mispredict -> stat_resolved=3, stat_mispredict=1.
